cheriot_dmem_responder: RTL and testbench



---
 rtl/cheriot_dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_cheriot_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheriot_dmem_responder.sv
// Tag-aware data memory responder for the CHERIoT data port.
// Delayed grant, fixed-latency in-order responses, tag cleared on plain stores.
module cheriot_dmem_responder #(
  parameter logic [31:0] BaseAddr = 32'h2000_0000,
  parameter int unsigned DepthW   = 4096,
  parameter int unsigned GntDelay = 0,
  parameter int unsigned RspLat   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_is_cap_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i
);

  localparam int unsigned AW = $clog2(DepthW);
  localparam bit ZeroWait = (GntDelay == 0);
  localparam logic [2:0] LastCnt = 3'(GntDelay - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e     st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  logic       gnt;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    gnt   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (data_req_i && !stall_i && ZeroWait) begin
          gnt = 1'b1;
        end else if (data_req_i && !ZeroWait) begin
          st_d  = WAIT;
          cnt_d = 3'd0;
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          st_d = IDLE;
        end else if (!stall_i) begin
          if (cnt_q == LastCnt) begin
            gnt  = 1'b1;
            st_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q  <= IDLE;
      cnt_q <= 3'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Grant is gated so nothing is accepted (or written) while in reset.
  assign data_gnt_o = gnt & rst_ni;

  logic [29:0]   off;
  logic [AW-1:0] idx;
  logic          in_rng, bad, ok_st, ok_ld;
  logic          unused_addr;

  assign off    = data_addr_i[31:2] - BaseAddr[31:2];
  assign in_rng = off < 30'(DepthW);
  assign idx    = off[AW-1:0];
  assign bad    = !in_rng || (data_is_cap_i && data_be_i != 4'hF);
  assign ok_st  = !bad && data_we_i;
  assign ok_ld  = !bad && !data_we_i;
  assign unused_addr = ^data_addr_i[1:0];

  logic [31:0]       mem_q [DepthW];
  logic [DepthW-1:0] tag_q;

  logic        acc_err, wr_en, tag_we, tag_d;
  logic [32:0] rsp_d;

  always_comb begin
    acc_err = 1'b0;
    wr_en   = 1'b0;
    tag_we  = 1'b0;
    tag_d   = 1'b0;
    rsp_d   = '0;
    unique case (1'b1)
      bad: acc_err = 1'b1;
      ok_st: begin
        wr_en  = |data_be_i;
        tag_we = data_is_cap_i || (|data_be_i);
        tag_d  = data_is_cap_i & data_wdata_i[32];
      end
      ok_ld: begin
        rsp_d = {data_is_cap_i & tag_q[idx], mem_q[idx]};
      end
      default: acc_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (data_gnt_o && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else if (data_gnt_o && tag_we) begin
      tag_q[idx] <= tag_d;
    end
  end

  logic        vld_q [RspLat];
  logic        err_q [RspLat];
  logic [32:0] rd_q  [RspLat];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RspLat; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        rd_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= data_gnt_o;
      err_q[0] <= data_gnt_o & acc_err;
      rd_q[0]  <= data_gnt_o ? rsp_d : 33'h0;
      for (int i = 1; i < RspLat; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        rd_q[i]  <= rd_q[i-1];
      end
    end
  end

  assign data_rvalid_o = vld_q[RspLat-1];
  assign data_err_o    = err_q[RspLat-1];
  assign data_rdata_o  = rd_q[RspLat-1];

endmodule

// File: tb/tb_cheriot_dmem_responder.sv
// Bench for cheriot_dmem_responder: three latency configs,
// directed and random traffic against a word/tag reference model.
module tb_cheriot_dmem_responder;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 256;

  function automatic int gd(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic int rl(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req   [3];
  logic        cap   [3];
  logic        we    [3];
  logic        stall [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [32:0] wd    [3];
  logic        gnt   [3];
  logic        rv    [3];
  logic        er    [3];
  logic [32:0] rd    [3];

  int total;
  int bad;
  int cyc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cheriot_dmem_responder #(
    .BaseAddr(BASE), .DepthW(DEPTH), .GntDelay(0), .RspLat(1)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .data_req_i(req[0]),
    .data_is_cap_i(cap[0]), .data_we_i(we[0]), .data_be_i(be[0]),
    .data_addr_i(addr[0]), .data_wdata_i(wd[0]), .data_gnt_o(gnt[0]),
    .data_rvalid_o(rv[0]), .data_rdata_o(rd[0]), .data_err_o(er[0]),
    .stall_i(stall[0])
  );

  cheriot_dmem_responder #(
    .BaseAddr(BASE), .DepthW(DEPTH), .GntDelay(3), .RspLat(3)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .data_req_i(req[1]),
    .data_is_cap_i(cap[1]), .data_we_i(we[1]), .data_be_i(be[1]),
    .data_addr_i(addr[1]), .data_wdata_i(wd[1]), .data_gnt_o(gnt[1]),
    .data_rvalid_o(rv[1]), .data_rdata_o(rd[1]), .data_err_o(er[1]),
    .stall_i(stall[1])
  );

  cheriot_dmem_responder #(
    .BaseAddr(BASE), .DepthW(DEPTH), .GntDelay(2), .RspLat(4)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .data_req_i(req[2]),
    .data_is_cap_i(cap[2]), .data_we_i(we[2]), .data_be_i(be[2]),
    .data_addr_i(addr[2]), .data_wdata_i(wd[2]), .data_gnt_o(gnt[2]),
    .data_rvalid_o(rv[2]), .data_rdata_o(rd[2]), .data_err_o(er[2]),
    .stall_i(stall[2])
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference memory: key = instance*65536 + word index, value {tag,data}.
  logic [32:0] mem [int];

  typedef struct {
    int          k;
    int          at;
    logic        e;
    logic [32:0] r;
  } rsp_t;

  rsp_t q [$];

  task automatic model(input int k, input bit w, input bit c,
                       input logic [3:0] b, input logic [31:0] a,
                       input logic [32:0] d, output logic e,
                       output logic [32:0] r);
    logic [29:0] off;
    logic [32:0] m;
    int          key;
    off = a[31:2] - BASE[31:2];
    e   = 1'b0;
    r   = '0;
    if (off >= 30'(DEPTH) || (c && b != 4'hF)) begin
      e = 1'b1;
      return;
    end
    key = k * 65536 + int'(off);
    m   = mem.exists(key) ? mem[key] : 33'h0;
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) m[8*i +: 8] = d[8*i +: 8];
      if (c) m[32] = d[32];
      else if (b != 4'h0) m[32] = 1'b0;
      mem[key] = m;
    end else begin
      r = {c & m[32], m[31:0]};
    end
  endtask

  // Request held until granted; expected grant cycle from the delay rule.
  task automatic issue(input int k, input bit w, input bit c,
                       input logic [3:0] b, input logic [31:0] a,
                       input logic [32:0] d, input logic [31:0] smask);
    int          un;
    bit          g;
    bit          got;
    bit          done;
    logic        e;
    logic [32:0] r;
    req[k]  = 1'b1;
    we[k]   = w;
    cap[k]  = c;
    be[k]   = b;
    addr[k] = a;
    wd[k]   = d;
    un      = 0;
    done    = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      stall[k] = (i < 32) ? smask[i] : 1'b0;
      if (gd(k) == 0) begin
        g = !stall[k];
      end else begin
        if (i > 0 && !stall[k]) un++;
        g = (i > 0) && !stall[k] && (un == gd(k));
      end
      @(negedge clk);
      got = gnt[k];
      check("gnt", 64'(got), 64'(g));
      if (got) begin
        model(k, w, c, b, a, d, e, r);
        q.push_back('{k, cyc + rl(k), e, r});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("gnt_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int k, input int n);
    req[k]   = 1'b0;
    stall[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int j;
      j = -1;
      for (int n = 0; n < q.size(); n++) begin
        if (q[n].k == k && j < 0) j = n;
      end
      if (j >= 0 && q[j].at == cyc) begin
        check("rvalid", 64'(rv[k]), 64'(1));
        check("err", 64'(er[k]), 64'(q[j].e));
        check("rdata", 64'(rd[k]), 64'(q[j].r));
        q.delete(j);
      end else begin
        check("rvalid_idle", 64'(rv[k]), 64'(0));
        check("rdata_idle", 64'(rd[k]), 64'(0));
        check("err_idle", 64'(er[k]), 64'(0));
      end
    end
  end

  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    for (int n = q.size() - 1; n >= 0; n--)
      if (q[n].k == k) q.delete(n);
    foreach (mem[key])
      if (key / 65536 == k) mem[key][32] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[k] = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int s;
    logic [31:0] lo;
    s  = $urandom_range(0, 9);
    lo = 32'($urandom_range(0, 3));
    if (s < 8) return BASE + 32'(4 * s) + lo;
    if (s == 8) return BASE + 32'(4 * DEPTH);
    return BASE - 32'd4;
  endfunction

  task automatic random_run(input int k, input int n);
    bit          w;
    bit          c;
    logic [3:0]  b;
    logic [32:0] d;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 2) == 0);
      b = 4'($urandom_range(0, 15));
      if (c && $urandom_range(0, 3) != 0) b = 4'hF;
      d = {1'($urandom_range(0, 1)), 32'($urandom)};
      issue(k, w, c, b, rnd_addr(), d, 32'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle(k, $urandom_range(1, 3));
    end
    idle(k, 8);
  endtask

  task automatic prewrite(input int k);
    for (int i = 0; i < 8; i++)
      issue(k, 1'b1, 1'b0, 4'hF, BASE + 32'(4 * i), {1'b0, 32'($urandom)}, 0);
    issue(k, 1'b1, 1'b0, 4'hF, BASE + 32'h10, 33'h0_1234_5678, 0);
    idle(k, 6);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req[k]   = 1'b0;
      cap[k]   = 1'b0;
      we[k]    = 1'b0;
      stall[k] = 1'b0;
      be[k]    = 4'h0;
      addr[k]  = 32'h0;
      wd[k]    = 33'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b1;
    @(negedge clk);
    check("rst_gnt", 64'(gnt[0]), 64'(0));
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait config: cap round trip, tag clear, plain load, errors.
    prewrite(0);
    issue(0, 1'b1, 1'b1, 4'hF, 32'h2000_0010, 33'h1_DEAD_BEEF, 0);
    issue(0, 1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 0);
    issue(0, 1'b1, 1'b0, 4'h1, 32'h2000_0010, 33'h0_0000_0055, 0);
    issue(0, 1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 0);
    issue(0, 1'b1, 1'b1, 4'hF, 32'h2000_0014, 33'h1_CAFE_F00D, 0);
    issue(0, 1'b0, 1'b0, 4'hF, 32'h2000_0014, 33'h0, 0);
    issue(0, 1'b0, 1'b0, 4'hF, BASE + 32'(4 * DEPTH), 33'h0, 0);
    issue(0, 1'b1, 1'b1, 4'h3, 32'h2000_0014, 33'h1_1111_1111, 0);
    issue(0, 1'b0, 1'b1, 4'hF, 32'h2000_0014, 33'h0, 0);
    issue(0, 1'b0, 1'b0, 4'hF, BASE - 32'd4, 33'h0, 0);
    idle(0, 4);
    random_run(0, 150);

    // Delayed grant: stall in cycles 2-3, then back-to-back requests.
    prewrite(1);
    issue(1, 1'b1, 1'b1, 4'hF, 32'h2000_0010, 33'h1_ABCD_0123, 32'b1100);
    issue(1, 1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 0);
    issue(1, 1'b0, 1'b1, 4'hF, 32'h2000_0010, 33'h0, 0);
    idle(1, 6);
    random_run(1, 80);

    // Reset with responses in flight; tags clear, data retained.
    prewrite(2);
    issue(2, 1'b1, 1'b1, 4'hF, 32'h2000_0008, 33'h1_5A5A_A5A5, 0);
    idle(2, 6);
    issue(2, 1'b0, 1'b1, 4'hF, 32'h2000_0008, 33'h0, 0);
    issue(2, 1'b0, 1'b1, 4'hF, 32'h2000_0000, 33'h0, 0);
    req[2] = 1'b0;
    do_reset(2);
    idle(2, 8);
    issue(2, 1'b0, 1'b1, 4'hF, 32'h2000_0008, 33'h0, 0);
    idle(2, 6);
    random_run(2, 60);

    check("drain", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
